// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The adel field of fetch_entry_t exists only when IF_ALIGN_CHECK_EN is defined.
package if_fetch_unit_pkg;

    localparam logic        RstEnable  = 1'b1;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [31:0] NopInst    = ZeroWord;
    localparam int unsigned IfBufDepth = 2;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;

    typedef struct packed {
`ifdef IF_ALIGN_CHECK_EN
        logic       adel;
`endif
        inst_addr_t pc;
        inst_t      inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Synchronous first-word-fall-through FIFO with clear; the head word is read
// straight from the storage registers. DEPTH must be a power of two >= 2.
module if_fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst == RstEnable || clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst != RstEnable && !clear_i && do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC generation, credit-limited imem requests and a
// response buffer toward ID. Optional misaligned-flush trap: IF_ALIGN_CHECK_EN.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = IfBufDepth
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic        id_adel_o
`endif
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    logic [31:0]  pc_q, pc_d, flush_pc, aq_head;
    logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, occ, aq_count;
    logic [CW:0]  in_use;
    logic         grant, pop, resp_keep, resp_push, adel_push, halt, credit_ok;
    logic         resp_full, resp_empty, aq_full, aq_empty;
    fetch_entry_t push_entry, head;

`ifdef IF_ALIGN_CHECK_EN
    logic halt_q, adel_pend_q, flush_misaligned;

    assign flush_misaligned = (flush_pc_i[1:0] != 2'b00);
    assign flush_pc         = flush_pc_i;
    assign halt             = halt_q;
    assign adel_push        = adel_pend_q && !flush_i;
    assign id_adel_o        = id_valid_o && head.adel;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            halt_q      <= 1'b0;
            adel_pend_q <= 1'b0;
        end else if (flush_i) begin
            halt_q      <= flush_misaligned;
            adel_pend_q <= flush_misaligned;
        end else begin
            adel_pend_q <= 1'b0;
        end
    end
`else
    assign flush_pc  = flush_pc_i & ~32'h3;
    assign halt      = 1'b0;
    assign adel_push = 1'b0;
`endif

    // A pop this cycle frees a slot at the same edge, so it is credited back
    // immediately; this is what sustains one instruction per cycle.
    assign in_use     = (CW+1)'(outst_q) + (CW+1)'(occ) - (CW+1)'(pop);
    assign credit_ok  = (in_use < (CW+1)'(BUF_DEPTH));
    assign imem_req_o = (rst != RstEnable) && !flush_i && credit_ok && (drop_q == '0) && !halt;
    assign imem_addr_o = pc_q;

    assign grant     = imem_req_o && imem_gnt_i;
    assign pop       = id_valid_o && id_ready_i;
    assign resp_keep = imem_rvalid_i && (drop_q == '0) && !flush_i;
    assign resp_push = resp_keep || adel_push;

    always_comb begin
        pc_d    = pc_q;
        outst_d = outst_q;
        drop_d  = drop_q;
        if (flush_i) begin
            pc_d    = flush_pc;
            outst_d = '0;
            drop_d  = drop_q + outst_q - CW'(imem_rvalid_i);
        end else begin
            if (grant) pc_d = pc_q + 32'd4;
            outst_d = outst_q + CW'(grant) - CW'(resp_keep);
            if (imem_rvalid_i && drop_q != '0) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = aq_head;
        push_entry.inst = imem_rdata_i;
`ifdef IF_ALIGN_CHECK_EN
        if (adel_pend_q) begin
            push_entry.pc   = pc_q;
            push_entry.inst = ZeroWord;
            push_entry.adel = 1'b1;
        end
`endif
    end

    if_fetch_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_addr_q (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush_i),
        .push_i  (grant),
        .data_i  (pc_q),
        .pop_i   (resp_keep),
        .data_o  (aq_head),
        .full_o  (aq_full),
        .empty_o (aq_empty),
        .count_o (aq_count)
    );

    if_fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(BUF_DEPTH)) u_resp_buf (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush_i),
        .push_i  (resp_push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (resp_full),
        .empty_o (resp_empty),
        .count_o (occ)
    );

    assign id_valid_o = !resp_empty;
    assign id_pc_o    = id_valid_o ? head.pc   : ZeroWord;
    assign id_inst_o  = id_valid_o ? head.inst : NopInst;

    always_ff @(posedge clk) begin
        if (rst != RstEnable && !flush_i) begin
            assert (!(resp_push && resp_full));
            assert (!(grant && aq_full));
            assert (!(resp_keep && aq_empty));
            assert (aq_count == outst_q);
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed scenarios push expected {pc, inst}
// pairs, a monitor compares every pair ID accepts, and a memory model answers fetches.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b0;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
`ifdef IF_ALIGN_CHECK_EN
    logic        id_adel_o;
`endif

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .flush_pc_i    (flush_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o)
`ifdef IF_ALIGN_CHECK_EN
        ,
        .id_adel_o     (id_adel_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_pair(input logic [31:0] pc, input logic [31:0] inst, input logic adel);
        exp_t e;
        e.pc = pc;
        e.inst = inst;
        e.adel = adel;
        exp_q.push_back(e);
    endtask

    // Memory model: word at address A is 32'hC0DE_0000 ^ A, returned lat cycles after grant.
    int unsigned lat = 1;
    bit          gnt_toggle = 1'b0;
    int unsigned cyc_n = 0;
    int unsigned n_grants = 0;
    int unsigned n_holds = 0;
    logic [31:0] pend_addr[$];
    int unsigned pend_due[$];
    logic [31:0] held_addr = '0;
    bit          held_v = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc_n++;
        imem_gnt_i    = gnt_toggle ? cyc_n[0] : 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        if (pend_due.size() > 0 && pend_due[0] <= cyc_n) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = 32'hC0DE_0000 ^ pend_addr[0];
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
            held_v = 1'b0;
        end else begin
            if (held_v && imem_req_o) begin
                n_holds++;
                check("addr_hold", imem_addr_o, held_addr);
            end
            held_v    = imem_req_o && !imem_gnt_i;
            held_addr = imem_addr_o;
            if (imem_req_o && imem_gnt_i) begin
                n_grants++;
                pend_addr.push_back(imem_addr_o);
                pend_due.push_back(cyc_n + lat);
            end
        end
    end

    // Monitor: a pair popped in a flush/reset cycle still counts as delivered.
    always @(negedge clk) begin
        if (id_valid_o && id_ready_i) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pair: got pc %h inst %h, expected none", id_pc_o, id_inst_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("id_pc", id_pc_o, e.pc);
                check("id_inst", id_inst_o, e.inst);
`ifdef IF_ALIGN_CHECK_EN
                check("id_adel", id_adel_o, e.adel);
`endif
            end
        end
        if (rst || flush_i) exp_q.delete();
    end

    task automatic cyc_();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg_check(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
        @(negedge clk);
        check(name, act_sel, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush_i = 1'b0;
        n_grants = 0;
        cyc_();
        @(negedge clk);
        check("rst_valid", id_valid_o, 32'd0);
        check("rst_pc", id_pc_o, 32'd0);
        check("rst_inst", id_inst_o, 32'd0);
        check("rst_req", imem_req_o, 32'd0);
        check("rst_addr", imem_addr_o, 32'h0000_0000);
        cyc_();
        rst = 1'b0;
    endtask

    task automatic drain(input string name, input int unsigned budget);
        int unsigned k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            cyc_();
            k++;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: streaming after reset, first pair two cycles after release
        lat = 1; gnt_toggle = 1'b0;
        do_reset();
        expect_pair(32'h0, 32'hC0DE_0000, 1'b0);
        expect_pair(32'h4, 32'hC0DE_0004, 1'b0);
        expect_pair(32'h8, 32'hC0DE_0008, 1'b0);
        id_ready_i = 1'b1;
        @(negedge clk); check("t1_valid_c0", id_valid_o, 32'd0); cyc_();
        @(negedge clk); check("t1_valid_c1", id_valid_o, 32'd0); cyc_();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check("t1_valid_stream", id_valid_o, 32'd1); cyc_();
        end
        id_ready_i = 1'b0;
        check("t1_drain", exp_q.size(), 32'd0);

        // 2: ID stall exhausts the credits, then the stream resumes in order
        do_reset();
        repeat (4) cyc_();
        @(negedge clk);
        check("t2_req_stalled", imem_req_o, 32'd0);
        check("t2_grants", n_grants, 32'd2);
        check("t2_valid", id_valid_o, 32'd1);
        check("t2_pc_hold", id_pc_o, 32'h0);
        check("t2_inst_hold", id_inst_o, 32'hC0DE_0000);
        cyc_();
        expect_pair(32'h0, 32'hC0DE_0000, 1'b0);
        expect_pair(32'h4, 32'hC0DE_0004, 1'b0);
        expect_pair(32'h8, 32'hC0DE_0008, 1'b0);
        expect_pair(32'hC, 32'hC0DE_000C, 1'b0);
        id_ready_i = 1'b1;
        drain("t2_drain", 30);
        id_ready_i = 1'b0;

        // 3: toggling grant, latency 3
        lat = 3; gnt_toggle = 1'b1;
        n_holds = 0;
        do_reset();
        expect_pair(32'h0, 32'hC0DE_0000, 1'b0);
        expect_pair(32'h4, 32'hC0DE_0004, 1'b0);
        expect_pair(32'h8, 32'hC0DE_0008, 1'b0);
        id_ready_i = 1'b1;
        drain("t3_drain", 40);
        id_ready_i = 1'b0;
        check("t3_hold_seen", (n_holds > 0) ? 32'd1 : 32'd0, 32'd1);

        // 4: flush with two requests in flight; late responses are discarded
        lat = 3; gnt_toggle = 1'b0;
        do_reset();
        cyc_();
        cyc_();
        flush_i = 1'b1; flush_pc_i = 32'h0000_0100;
        @(negedge clk);
        check("t4_req_in_flush", imem_req_o, 32'd0);
        check("t4_grants", n_grants, 32'd2);
        cyc_();
        flush_i = 1'b0;
        expect_pair(32'h100, 32'hC0DE_0100, 1'b0);
        expect_pair(32'h104, 32'hC0DE_0104, 1'b0);
        expect_pair(32'h108, 32'hC0DE_0108, 1'b0);
        id_ready_i = 1'b1;
        @(negedge clk);
        check("t4_valid_after", id_valid_o, 32'd0);
        check("t4_req_dropping", imem_req_o, 32'd0);
        cyc_();
        drain("t4_drain", 40);
        id_ready_i = 1'b0;

        // 5: reset mid-stream while a response is returning
        lat = 1;
        do_reset();
        expect_pair(32'h0, 32'hC0DE_0000, 1'b0);
        expect_pair(32'h4, 32'hC0DE_0004, 1'b0);
        expect_pair(32'h8, 32'hC0DE_0008, 1'b0);
        id_ready_i = 1'b1;
        repeat (5) cyc_();
        id_ready_i = 1'b0;
        check("t5_pre_reset", exp_q.size(), 32'd0);
        check("t5_rvalid_at_rst", imem_rvalid_i, 32'd1);
        do_reset();
        expect_pair(32'h0, 32'hC0DE_0000, 1'b0);
        expect_pair(32'h4, 32'hC0DE_0004, 1'b0);
        id_ready_i = 1'b1;
        @(negedge clk); check("t5_no_spurious0", id_valid_o, 32'd0); cyc_();
        @(negedge clk); check("t5_no_spurious1", id_valid_o, 32'd0); cyc_();
        drain("t5_drain", 20);
        id_ready_i = 1'b0;

`ifdef IF_ALIGN_CHECK_EN
        // 6: misaligned flush target traps once and halts fetch
        do_reset();
        flush_i = 1'b1; flush_pc_i = 32'h0000_0102;
        cyc_();
        flush_i = 1'b0;
        @(negedge clk);
        check("t6_req_after_flush", imem_req_o, 32'd0);
        check("t6_valid_c1", id_valid_o, 32'd0);
        expect_pair(32'h102, 32'h0, 1'b1);
        repeat (3) cyc_();
        @(negedge clk);
        check("t6_req_halted", imem_req_o, 32'd0);
        check("t6_valid_trap", id_valid_o, 32'd1);
        cyc_();
        id_ready_i = 1'b1;
        drain("t6_drain", 10);
        id_ready_i = 1'b0;
        repeat (3) cyc_();
        @(negedge clk);
        check("t6_still_halted", imem_req_o, 32'd0);
        check("t6_no_grants", n_grants, 32'd0);
        cyc_();
        flush_i = 1'b1; flush_pc_i = 32'h0000_0200;
        cyc_();
        flush_i = 1'b0;
        expect_pair(32'h200, 32'hC0DE_0200, 1'b0);
        id_ready_i = 1'b1;
        drain("t6_resume", 20);
        id_ready_i = 1'b0;
`else
        // 6: low PC bits of a flush target are ignored
        do_reset();
        flush_i = 1'b1; flush_pc_i = 32'h0000_0203;
        cyc_();
        flush_i = 1'b0;
        @(negedge clk);
        check("t6_req_addr", imem_addr_o, 32'h0000_0200);
        expect_pair(32'h200, 32'hC0DE_0200, 1'b0);
        expect_pair(32'h204, 32'hC0DE_0204, 1'b0);
        cyc_();
        id_ready_i = 1'b1;
        drain("t6_drain", 20);
        id_ready_i = 1'b0;
`endif

        repeat (3) cyc_();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
